// File: rtl/nextasic_transmitter_if.sv
// Word handshake between a producer and the NeXT ASIC serial transmitter.
interface nextasic_transmitter_if #(
  parameter int WIDTH = 40
);
  logic [WIDTH-1:0] data;
  logic             valid;
  logic             ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/nextasic_transmitter.sv
// NeXT ASIC single-wire framed-link transmitter: start bit high, WIDTH bits MSB
// first, then at least GAP low cycles; one-word holding buffer for overlap.
module nextasic_transmitter #(
  parameter int WIDTH = 40,
  parameter int GAP   = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  nextasic_transmitter_if.slave  bus,
  output logic                   sout,
  output logic                   busy,
  output logic                   done
);
  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int GAP_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_START,
    ST_SHIFT,
    ST_GAP
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic [WIDTH-1:0]   hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [GAP_W-1:0]   gap_cnt_q, gap_cnt_d;
  logic               sout_q, sout_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               ready;

  assign ready     = !hold_full_q && !reset;
  assign bus.ready = ready;
  assign sout      = sout_q;
  assign busy      = busy_q;
  assign done      = done_q;

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bit_cnt_d   = bit_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    sout_d      = sout_q;
    done_d      = 1'b0;

    // ready is low whenever the buffer is full, so this load can never
    // collide with the transfers below (they only happen when full).
    if (bus.valid && ready) begin
      hold_d      = bus.data;
      hold_full_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        sout_d = 1'b0;
        if (hold_full_q) begin
          shift_d     = hold_q;
          hold_full_d = 1'b0;
          sout_d      = 1'b1;
          state_d     = ST_START;
        end
      end
      ST_START: begin
        sout_d    = shift_q[WIDTH-1];
        shift_d   = {shift_q[WIDTH-2:0], 1'b0};
        bit_cnt_d = CNT_W'(1);
        state_d   = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (bit_cnt_q == CNT_W'(WIDTH)) begin
          sout_d    = 1'b0;
          done_d    = 1'b1;
          gap_cnt_d = GAP_W'(1);
          state_d   = ST_GAP;
        end else begin
          sout_d    = shift_q[WIDTH-1];
          shift_d   = {shift_q[WIDTH-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
        end
      end
      ST_GAP: begin
        sout_d = 1'b0;
        if (gap_cnt_q == GAP_W'(GAP)) begin
          if (hold_full_q) begin
            shift_d     = hold_q;
            hold_full_d = 1'b0;
            sout_d      = 1'b1;
            state_d     = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      bit_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      sout_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bit_cnt_q   <= bit_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      sout_q      <= sout_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end
endmodule
